// File: rtl/plot_pkg.sv
// Shared types and defaults for the VGA pixel-write queue: coordinate widths,
// screen defaults, FSM state encoding and the packed pixel record.
package plot_pkg;

   localparam int COORD_W  = 8;
   localparam int COLOUR_W = 9;
   localparam int PIX_W    = 2 * COORD_W + COLOUR_W;

   localparam int                  DEF_SCREEN_W  = 160;
   localparam int                  DEF_SCREEN_H  = 120;
   localparam logic [COLOUR_W-1:0] DEF_BG_COLOUR = 9'h000;

   typedef enum logic {
      ST_DRAIN = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   typedef struct packed {
      logic [COORD_W-1:0]  x;
      logic [COORD_W-1:0]  y;
      logic [COLOUR_W-1:0] colour;
   } pixel_t;

endpackage

// File: rtl/plot_fifo.sv
// Synchronous DEPTH-entry pixel FIFO (DEPTH a power of two) with occupancy
// count. Pushes when full and pops when empty are ignored.
module plot_fifo
   import plot_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [PIX_W-1:0]         din,
   output logic [PIX_W-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [PIX_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // NOTE: the storage array has no reset; only pointers and count define
   // validity, which keeps the array as plain RAM/regfile without reset muxes.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/vga_plot_queue.sv
// Pixel-write queue feeding the VGA adapter: buffers (x,y,colour) writes and
// drains one per clock, with a full-screen background sweep on clear_req.
// Optional define PLOT_DEDUP_EN drops writes identical to the last pushed one.
module vga_plot_queue
   import plot_pkg::*;
#(
   parameter int                  DEPTH     = 8,
   parameter int                  SCREEN_W  = DEF_SCREEN_W,
   parameter int                  SCREEN_H  = DEF_SCREEN_H,
   parameter logic [COLOUR_W-1:0] BG_COLOUR = DEF_BG_COLOUR
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [COORD_W-1:0]  in_x,
   input  logic [COORD_W-1:0]  in_y,
   input  logic [COLOUR_W-1:0] in_colour,
   input  logic                clear_req,
   input  logic                hold,
   output logic                clear_busy,
   output logic                plot,
   output logic [COORD_W-1:0]  x_out,
   output logic [COORD_W-1:0]  y_out,
   output logic [COLOUR_W-1:0] colour_out
);

   localparam int                 CNT_W  = $clog2(DEPTH) + 1;
   localparam logic [COORD_W-1:0] X_LIM  = COORD_W'(SCREEN_W);
   localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(SCREEN_H);
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_W - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_H - 1);

   state_t             state, state_nxt;
   logic [COORD_W-1:0] sx, sy;
   pixel_t             in_pix, head, out_pix, pix_nxt;
   logic [PIX_W-1:0]   fifo_dout;
   logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [CNT_W-1:0]   fifo_count;
   logic               in_range, is_dup;
   logic               start_clear, sweep_adv, sweep_last, plot_nxt;

   assign in_pix     = {in_x, in_y, in_colour};
   assign head       = pixel_t'(fifo_dout);
   assign in_ready   = (fifo_count != CNT_W'(DEPTH));
   assign in_range   = (in_x < X_LIM) && (in_y < Y_LIM);
   assign fifo_push  = in_valid && !fifo_full && in_range && !is_dup;
   assign sweep_last = (sx == X_LAST) && (sy == Y_LAST);
   assign clear_busy = (state == ST_CLEAR);

   plot_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (in_pix),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

`ifdef PLOT_DEDUP_EN
   logic   last_valid;
   pixel_t last_pix;

   assign is_dup = last_valid && (in_pix == last_pix);

   // Entering CLEAR invalidates even if a push lands in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_valid <= 1'b0;
         last_pix   <= '0;
      end else if (start_clear) begin
         last_valid <= 1'b0;
      end else if (fifo_push) begin
         last_valid <= 1'b1;
         last_pix   <= in_pix;
      end
   end
`else
   assign is_dup = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_DRAIN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_DRAIN: if (clear_req) state_nxt = ST_CLEAR;
         ST_CLEAR: if (!hold && sweep_last) state_nxt = ST_DRAIN;
         default:  state_nxt = ST_DRAIN;
      endcase
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      fifo_pop    = 1'b0;
      start_clear = 1'b0;
      sweep_adv   = 1'b0;
      plot_nxt    = 1'b0;
      pix_nxt     = out_pix;
      case (state)
         ST_DRAIN: begin
            if (clear_req) begin
               start_clear = 1'b1;
            end else if (!hold && !fifo_empty) begin
               fifo_pop = 1'b1;
               plot_nxt = 1'b1;
               pix_nxt  = head;
            end
         end
         ST_CLEAR: begin
            if (!hold) begin
               sweep_adv = 1'b1;
               plot_nxt  = 1'b1;
               pix_nxt   = '{x: sx, y: sy, colour: BG_COLOUR};
            end
         end
         default: ;
      endcase
   end

   // Raster sweep counters; sy overshoots after the last pixel but is
   // reloaded on the next clear entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sx <= '0;
         sy <= '0;
      end else if (start_clear) begin
         sx <= '0;
         sy <= '0;
      end else if (sweep_adv) begin
         if (sx == X_LAST) begin
            sx <= '0;
            sy <= sy + 1'b1;
         end else begin
            sx <= sx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         plot    <= 1'b0;
         out_pix <= '0;
      end else begin
         plot    <= plot_nxt;
         out_pix <= pix_nxt;
      end
   end

   assign x_out      = out_pix.x;
   assign y_out      = out_pix.y;
   assign colour_out = out_pix.colour;

endmodule

// File: tb/tb_vga_plot_queue.sv
// Self-checking bench for vga_plot_queue: a queue-based behavioural model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_vga_plot_queue;
   import plot_pkg::*;

   localparam int          DEPTH = 8;
   localparam int          W     = 160;
   localparam int          H     = 120;
   localparam logic [8:0]  BG    = 9'h000;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_x = '0;
   logic [7:0] in_y = '0;
   logic [8:0] in_colour = '0;
   logic       clear_req = 1'b0;
   logic       hold = 1'b0;
   logic       clear_busy;
   logic       plot;
   logic [7:0] x_out;
   logic [7:0] y_out;
   logic [8:0] colour_out;

   vga_plot_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_colour  (in_colour),
      .clear_req  (clear_req),
      .hold       (hold),
      .clear_busy (clear_busy),
      .plot       (plot),
      .x_out      (x_out),
      .y_out      (y_out),
      .colour_out (colour_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int plot_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a pixel queue, a sweep index over the screen in
   // raster order, and the last registered output.
   pixel_t mq[$];
   bit     m_clearing = 1'b0;
   int     m_idx = 0;
   bit     m_plot = 1'b0;
   pixel_t m_out = '0;
   bit     m_last_valid = 1'b0;
   pixel_t m_last = '0;

   always @(posedge clk or posedge reset) begin
      bit     accept;
      bit     enter;
      bit     dup;
      pixel_t np;
      if (reset) begin
         mq.delete();
         m_clearing   = 1'b0;
         m_idx        = 0;
         m_plot       = 1'b0;
         m_out        = '0;
         m_last_valid = 1'b0;
      end else begin
         accept = in_valid && (mq.size() < DEPTH);
         enter  = 1'b0;
         if (!m_clearing) begin
            if (clear_req) begin
               enter  = 1'b1;
               m_plot = 1'b0;
            end else if (!hold && mq.size() > 0) begin
               m_out  = mq.pop_front();
               m_plot = 1'b1;
            end else begin
               m_plot = 1'b0;
            end
         end else if (!hold) begin
            m_out  = '{x: 8'(m_idx % W), y: 8'(m_idx / W), colour: BG};
            m_plot = 1'b1;
            m_idx++;
            if (m_idx == W * H) m_clearing = 1'b0;
         end else begin
            m_plot = 1'b0;
         end
         if (enter) begin
            m_clearing = 1'b1;
            m_idx      = 0;
         end
         np  = {in_x, in_y, in_colour};
         dup = 1'b0;
`ifdef PLOT_DEDUP_EN
         dup = m_last_valid && (np == m_last);
`endif
         if (accept && in_x < W && in_y < H && !dup) begin
            mq.push_back(np);
            m_last       = np;
            m_last_valid = 1'b1;
         end
         if (enter) m_last_valid = 1'b0;
      end
   end

   always @(negedge clk) begin
      check("plot",       plot,       m_plot);
      check("x_out",      x_out,      m_out.x);
      check("y_out",      y_out,      m_out.y);
      check("colour_out", colour_out, m_out.colour);
      check("clear_busy", clear_busy, m_clearing);
      check("in_ready",   in_ready,   mq.size() < DEPTH);
      if (plot) plot_count++;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [8:0] c);
      bit take;
      in_valid  = 1'b1;
      in_x      = x;
      in_y      = y;
      in_colour = c;
      for (int k = 0; k < 64; k++) begin
         take = in_ready;
         step();
         if (take) return;
      end
      check("send_timeout", 32'd0, 32'd1);
   endtask

   int  c0, c1;
   bit  done;

   initial begin
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      check("rst_plot",  plot, 0);
      check("rst_ready", in_ready, 1);
      check("rst_busy",  clear_busy, 0);
      check("rst_x",     x_out, 0);

      // Single write latency
      send(8'd3, 8'd4, 9'h1C0);
      in_valid = 1'b0;
      check("lat_pre_plot", plot, 0);
      step();
      check("lat_plot",   plot, 1);
      check("lat_x",      x_out, 3);
      check("lat_y",      y_out, 4);
      check("lat_colour", colour_out, 9'h1C0);
      step();
      check("lat_after", plot, 0);

      // Fill under hold, ninth write stalls
      hold = 1'b1;
      for (int i = 0; i < DEPTH; i++) send(8'(10 + i), 8'd20, 9'(i));
      check("full_ready", in_ready, 0);
      in_valid = 1'b1; in_x = 8'd18; in_y = 8'd20; in_colour = 9'd8;
      c0 = plot_count;
      repeat (3) step();
      check("full_stall_ready", in_ready, 0);
      check("full_hold_plot",   plot, 0);
      hold = 1'b0;
      send(8'd18, 8'd20, 9'd8);
      in_valid = 1'b0;
      repeat (12) step();
      check("full_drain_count", plot_count - c0, 9);

      // Out-of-range writes
      c0 = plot_count;
      send(8'd160, 8'd0, 9'h1FF);
      send(8'd0, 8'd120, 9'h1FF);
      in_valid = 1'b0;
      repeat (4) step();
      check("oor_plots", plot_count - c0, 0);
      check("oor_count", dut.u_fifo.count, 0);

      // Clear with two pixels queued
      hold = 1'b1;
      send(8'd7, 8'd8, 9'h01F);
      send(8'd9, 8'd10, 9'h02F);
      in_valid = 1'b0;
      c0 = plot_count;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      hold = 1'b0;
      check("clr_busy", clear_busy, 1);
      done = 1'b0;
      for (int k = 0; k < W * H + 100; k++) begin
         step();
         if (!clear_busy) begin
            done = 1'b1;
            break;
         end
      end
      check("clr_done", done, 1);
      check("clr_last_x", x_out, W - 1);
      check("clr_last_y", y_out, H - 1);
      check("clr_last_c", colour_out, BG);
      step();
      check("clr_count", plot_count - c0, W * H);
      check("clr_q_x", x_out, 7);
      check("clr_q_y", y_out, 8);
      c1 = plot_count;
      repeat (4) step();
      check("clr_q_count", plot_count - c1, 2);

      // Reset mid-sweep
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      c0 = plot_count;
      for (int k = 0; k < 1000 && plot_count - c0 < 500; k++) step();
      reset = 1'b1;
      #1;
      check("mid_rst_plot",  plot, 0);
      check("mid_rst_x",     x_out, 0);
      check("mid_rst_y",     y_out, 0);
      check("mid_rst_c",     colour_out, 0);
      check("mid_rst_busy",  clear_busy, 0);
      check("mid_rst_ready", in_ready, 1);
      step();
      step();
      reset = 1'b0;
      send(8'd33, 8'd44, 9'h0AA);
      in_valid = 1'b0;
      step();
      check("post_rst_plot", plot, 1);
      check("post_rst_x",    x_out, 33);
      check("post_rst_busy", clear_busy, 0);
      step();
      step();
      check("post_rst_idle", plot, 0);

      // Duplicate writes
      c0 = plot_count;
      send(8'd5, 8'd5, 9'h038);
      send(8'd5, 8'd5, 9'h038);
      send(8'd5, 8'd5, 9'h007);
      in_valid = 1'b0;
      repeat (6) step();
`ifdef PLOT_DEDUP_EN
      check("dedup_plots", plot_count - c0, 2);
`else
      check("dedup_plots", plot_count - c0, 3);
`endif

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         in_valid = 1'($urandom_range(0, 1));
         hold     = ($urandom_range(0, 9) < 2);
         if ($urandom_range(0, 1) == 0) begin
            in_x      = 8'($urandom_range(0, 3));
            in_y      = 8'($urandom_range(0, 3));
            in_colour = 9'($urandom_range(0, 3));
         end else begin
            in_x      = 8'($urandom_range(0, 170));
            in_y      = 8'($urandom_range(0, 130));
            in_colour = 9'($urandom_range(0, 511));
         end
         step();
      end
      in_valid = 1'b0;
      hold = 1'b0;
      repeat (20) step();
      check("final_empty", dut.u_fifo.count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
